// File: rtl/data_map_pkg.sv
// Address map, region decode enum and status-register layout for the data-side responder.
package data_map_pkg;

  localparam logic [31:0] CYCLE_ADDR      = 32'h8000_0000;
  localparam logic [31:0] PIX_STATUS_ADDR = 32'h8000_0004;
  localparam logic [31:0] PIX_DATA_ADDR   = 32'h8000_0008;
  localparam int unsigned OVF_BIT         = 31;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_CYCLE,
    REG_PIX_STATUS,
    REG_PIX_DATA,
    REG_NONE
  } region_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Camera pixel FIFO with extra-bit pointers and a sticky overflow flag; the camera cannot be stalled.
module pix_fifo #(
  parameter int PIX_DEPTH = 16,
  parameter int PIX_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PIX_W-1:0]             din,
  output logic [PIX_W-1:0]             dout,
  output logic [$clog2(PIX_DEPTH):0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  input  logic                         clr_ovf
);

  localparam int AW = $clog2(PIX_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_C = (AW+1)'(PIX_DEPTH);

  logic [PIX_W-1:0] mem_r [PIX_DEPTH];
  logic [AW:0]      wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s, count_s;
  logic             do_push_s, do_pop_s, ovf_r, ovf_s, empty_r, full_r;

  // Next-state: a pop from an empty FIFO does nothing, a pop frees room for a same-cycle push.
  always_comb begin
    do_pop_s  = pop & ~empty_r;
    do_push_s = push & (~full_r | do_pop_s);
    wr_ptr_s  = do_push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    rd_ptr_s  = do_pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    count_s   = wr_ptr_s - rd_ptr_s;
    if (clr_ovf) begin
      ovf_s = 1'b0;
    end else if (push & full_r & ~do_pop_s) begin
      ovf_s = 1'b1;
    end else begin
      ovf_s = ovf_r;
    end
  end

  // Pointer, flag and overflow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      ovf_r    <= 1'b0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      ovf_r    <= ovf_s;
      empty_r  <= (count_s == '0);
      full_r   <= (count_s == DEPTH_C);
    end
  end

  // Pixel storage.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  assign dout     = mem_r[rd_ptr_r[AW-1:0]];
  assign count    = wr_ptr_r - rd_ptr_r;
  assign full     = full_r;
  assign empty    = empty_r;
  assign overflow = ovf_r;

endmodule

// File: rtl/data_bus_responder.sv
// Data-side load/store responder: word RAM plus MMIO cycle counter and camera pixel FIFO.
// The pixel FIFO window is built only when PIX_FIFO_EN is defined.
module data_bus_responder
  import data_map_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int PIX_DEPTH = 16,
  parameter int PIX_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      WriteAddress,
  input  logic [31:0]      WriteData,
  input  logic             write_enable,
  input  logic             read_enable,
  output logic [31:0]      ReadData,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_irq
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  logic [31:0]       mem_r [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx_s;
  region_t           region_s;
  logic [31:0]       cycle_r, read_data_r, rdata_s, status_s, pixel_s;
  logic              ram_we_s, cycle_clr_s;

  assign ram_idx_s = WriteAddress[RAM_AW+1:2];

  // Region decode; the RAM test uses the full byte address.
  always_comb begin
    if ({1'b0, WriteAddress} < RAM_BYTES) begin
      region_s = REG_RAM;
    end else begin
      case (word_align(WriteAddress))
        CYCLE_ADDR:      region_s = REG_CYCLE;
        PIX_STATUS_ADDR: region_s = REG_PIX_STATUS;
        PIX_DATA_ADDR:   region_s = REG_PIX_DATA;
        default:         region_s = REG_NONE;
      endcase
    end
  end

  assign ram_we_s    = write_enable & (region_s == REG_RAM);
  assign cycle_clr_s = write_enable & (region_s == REG_CYCLE);

`ifdef PIX_FIFO_EN
  logic [$clog2(PIX_DEPTH):0] pix_count_s;
  logic [PIX_W-1:0]           pix_dout_s;
  logic                       pix_empty_s, pix_full_unused_s, pix_ovf_s;

  pix_fifo #(
    .PIX_DEPTH (PIX_DEPTH),
    .PIX_W     (PIX_W)
  ) u_pix_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pix_valid),
    .pop      (read_enable & (region_s == REG_PIX_DATA)),
    .din      (pix_data),
    .dout     (pix_dout_s),
    .count    (pix_count_s),
    .full     (pix_full_unused_s),
    .empty    (pix_empty_s),
    .overflow (pix_ovf_s),
    .clr_ovf  (write_enable & (region_s == REG_PIX_STATUS) & WriteData[OVF_BIT])
  );

  assign status_s = {pix_ovf_s, 15'd0, 16'(pix_count_s)};
  assign pixel_s  = pix_empty_s ? 32'd0 : 32'(pix_dout_s);
  assign pix_irq  = ~pix_empty_s;
`else
  logic pix_unused_s;
  assign pix_unused_s = ^{pix_valid, pix_data};
  assign status_s     = 32'd0;
  assign pixel_s      = 32'd0;
  assign pix_irq      = 1'b0;
`endif

  // Word RAM; not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[ram_idx_s] <= WriteData;
    end
  end

  // Free-running cycle counter; a store clears it and wins over the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_r <= 32'd0;
    end else if (cycle_clr_s) begin
      cycle_r <= 32'd0;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end

  // Load mux over pre-edge state, giving read-before-write behaviour.
  always_comb begin
    case (region_s)
      REG_RAM:        rdata_s = mem_r[ram_idx_s];
      REG_CYCLE:      rdata_s = cycle_r;
      REG_PIX_STATUS: rdata_s = status_s;
      REG_PIX_DATA:   rdata_s = pixel_s;
      default:        rdata_s = 32'd0;
    endcase
  end

  // Registered load data, updated every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_r <= 32'd0;
    end else begin
      read_data_r <= rdata_s;
    end
  end

  assign ReadData = read_data_r;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench: queue/array reference model, per-cycle compare process, directed literal checks.
module tb_data_bus_responder;

  localparam int RW = 64;
  localparam int PD = 16;
  localparam int PW = 8;
`ifdef PIX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   WriteAddress = 32'h4000_0000;
  logic [31:0]   WriteData = 32'd0;
  logic          write_enable = 1'b0;
  logic          read_enable = 1'b0;
  logic [31:0]   ReadData;
  logic          pix_valid = 1'b0;
  logic [PW-1:0] pix_data = '0;
  logic          pix_irq;

  data_bus_responder #(.RAM_WORDS(RW), .PIX_DEPTH(PD), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset), .WriteAddress(WriteAddress), .WriteData(WriteData),
    .write_enable(write_enable), .read_enable(read_enable), .ReadData(ReadData),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_irq(pix_irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   ram_m [RW];
  logic [PW-1:0] q_m [$];
  logic          ovf_m = 1'b0;
  logic [31:0]   cyc_m = 32'd0;
  logic [31:0]   exp_rd = 32'd0;
  logic          exp_irq = 1'b0;
  logic          check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare process: checks outputs produced by each edge against the model.
  always @(posedge clk) begin
    #1;
    if (check_en) begin
      chk("read_data", ReadData, exp_rd);
      chk("pix_irq", {31'd0, pix_irq}, {31'd0, exp_irq});
    end
  end

  // Drive one bus cycle at a negedge, advance the model, return at the next negedge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic re, input logic pv, input logic [PW-1:0] pd);
    logic [31:0] rd;
    logic [31:0] w;
    bit popped, full, clr;
    WriteAddress = a; WriteData = wd; write_enable = we; read_enable = re;
    pix_valid = pv; pix_data = pd;
    w = a & 32'hFFFF_FFFC;
    popped = 1'b0; clr = 1'b0;
    if (a < 32'(RW * 4)) begin
      rd = ram_m[a >> 2];
      if (we) ram_m[a >> 2] = wd;
    end else if (w == 32'h8000_0000) begin
      rd = cyc_m;
    end else if (w == 32'h8000_0004) begin
      rd = FIFO_EN ? {ovf_m, 15'd0, 16'(q_m.size())} : 32'd0;
      clr = FIFO_EN && we && wd[31];
    end else if (w == 32'h8000_0008) begin
      rd = (FIFO_EN && q_m.size() != 0) ? 32'(q_m[0]) : 32'd0;
      popped = FIFO_EN && re && q_m.size() != 0;
    end else begin
      rd = 32'd0;
    end
    cyc_m = (we && w == 32'h8000_0000) ? 32'd0 : cyc_m + 32'd1;
    if (FIFO_EN) begin
      full = (q_m.size() == PD);
      if (popped) void'(q_m.pop_front());
      if (clr) ovf_m = 1'b0;
      if (pv) begin
        if (!full || popped) q_m.push_back(pd);
        else if (!clr) ovf_m = 1'b1;
      end
    end
    exp_rd   = rd;
    exp_irq  = FIFO_EN && q_m.size() != 0;
    check_en = !$isunknown(rd);
    @(negedge clk);
  endtask

  // Assert reset at a negedge, check the asynchronous effect, release at the next negedge.
  task automatic do_reset();
    check_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("reset_read_data", ReadData, 32'd0);
    chk("reset_pix_irq", {31'd0, pix_irq}, 32'd0);
    q_m.delete();
    ovf_m = 1'b0; cyc_m = 32'd0; exp_rd = 32'd0; exp_irq = 1'b0;
    write_enable = 1'b0; read_enable = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle(input logic pv, input logic [PW-1:0] pd);
    step(32'h4000_0000, 32'd0, 1'b0, 1'b0, pv, pd);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic we, re;
    int r;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < RW; i++) step(32'(i * 4), $urandom, 1'b1, 1'b0, 1'b0, '0);

    // Counter from reset release, then clear by store.
    do_reset();
    for (int i = 0; i < 10; i++) idle(1'b0, '0);
    step(32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0, '0);
    chk("cycle_at_10", ReadData, 32'd10);
    step(32'h8000_0000, 32'h1234_5678, 1'b1, 1'b0, 1'b0, '0);
    step(32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0, '0);
    chk("cycle_cleared", ReadData, 32'd0);

    // RAM store/load, byte offset ignored, read-before-write.
    step(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, '0);
    step(32'h10, 32'd0, 1'b0, 1'b1, 1'b0, '0);
    chk("ram_load", ReadData, 32'hDEAD_BEEF);
    step(32'h13, 32'd0, 1'b0, 1'b1, 1'b0, '0);
    chk("ram_load_offset", ReadData, 32'hDEAD_BEEF);
    step(32'h20, 32'h5, 1'b1, 1'b0, 1'b0, '0);
    step(32'h20, 32'h1, 1'b1, 1'b1, 1'b0, '0);
    chk("ram_rbw_old", ReadData, 32'h5);
    step(32'h20, 32'd0, 1'b0, 1'b1, 1'b0, '0);
    chk("ram_rbw_new", ReadData, 32'h1);

    if (FIFO_EN) begin
      idle(1'b1, 8'h11); idle(1'b1, 8'h22); idle(1'b1, 8'h33);
      step(32'h8000_0004, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      chk("fifo_count3", ReadData, 32'd3);
      step(32'h8000_0008, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      chk("pop_11", ReadData, 32'h11);
      step(32'h8000_0008, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      chk("pop_22", ReadData, 32'h22);
      step(32'h8000_0008, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      chk("pop_33", ReadData, 32'h33);
      step(32'h8000_0008, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      chk("pop_empty", ReadData, 32'd0);
      step(32'h8000_0004, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      chk("drained_count", ReadData, 32'd0);
      chk("drained_irq", {31'd0, pix_irq}, 32'd0);
      for (int i = 0; i < 17; i++) idle(1'b1, 8'(i + 1));
      step(32'h8000_0004, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      chk("overflow_status", ReadData, 32'h8000_0010);
      step(32'h8000_0004, 32'h8000_0000, 1'b1, 1'b0, 1'b0, '0);
      step(32'h8000_0004, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      chk("overflow_cleared", ReadData, 32'h0000_0010);
      step(32'h8000_0008, 32'd0, 1'b0, 1'b1, 1'b1, 8'hAA);
      chk("full_pushpop_data", ReadData, 32'h01);
      step(32'h8000_0004, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      chk("full_pushpop_status", ReadData, 32'h0000_0010);
      for (int i = 0; i < 16; i++) step(32'h8000_0008, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      step(32'h8000_0008, 32'd0, 1'b0, 1'b1, 1'b1, 8'h55);
      chk("empty_pushpop_data", ReadData, 32'd0);
      step(32'h8000_0004, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      chk("empty_pushpop_count", ReadData, 32'd1);
      idle(1'b1, 8'h66); idle(1'b1, 8'h77);
      do_reset();
      step(32'h8000_0004, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      chk("reset_count", ReadData, 32'd0);
    end else begin
      idle(1'b1, 8'h11); idle(1'b1, 8'h22);
      step(32'h8000_0004, 32'd0, 1'b0, 1'b1, 1'b0, '0);
      chk("no_fifo_status", ReadData, 32'd0);
      step(32'h8000_0008, 32'd0, 1'b0, 1'b1, 1'b1, 8'h33);
      chk("no_fifo_data", ReadData, 32'd0);
      chk("no_fifo_irq", {31'd0, pix_irq}, 32'd0);
    end

    // Randomized traffic over all regions.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      r = $urandom_range(0, 9);
      wd = $urandom;
      we = 1'b0;
      re = 1'b0;
      if (r <= 4) begin
        a = 32'($urandom_range(0, RW - 1) * 4 + $urandom_range(0, 3));
        we = ($urandom_range(0, 3) == 0);
        re = ~we;
      end else if (r == 5) begin
        a = 32'h8000_0000 + 32'($urandom_range(0, 3));
        we = ($urandom_range(0, 7) == 0);
      end else if (r == 6) begin
        a = 32'h8000_0004;
        we = ($urandom_range(0, 3) == 0);
      end else if (r <= 8) begin
        a = 32'h8000_0008;
        re = ($urandom_range(0, 3) != 0);
        we = ($urandom_range(0, 7) == 0);
      end else begin
        case ($urandom_range(0, 3))
          0: a = 32'h8000_000C;
          1: a = 32'(RW * 4) + 32'($urandom_range(0, 63) * 4);
          2: a = 32'hFFFF_FFFC;
          default: a = 32'h8000_0100;
        endcase
        we = $urandom_range(0, 1) == 1;
      end
      step(a, wd, we, re, ($urandom_range(0, 1) == 1), PW'($urandom));
    end

    check_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
